riscv_v_pipe_ctrl: RTL and testbench

//  Stall/flush sequencer for the 5-stage core pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB stage registers).

---
 rtl/riscv_v_pipe_ctrl.sv | 112 +++++++++++
 tb/tb_riscv_v_pipe_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/riscv_v_pipe_ctrl.sv
// riscv_v_pipe_ctrl: stall/flush sequencer for the 5-stage pipeline.
// Drives the en/flush pins of the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers and the PC enable.
// It resolves load-use hazards, taken-branch squashes, multi-cycle EX ops and data-memory wait states.
// It also tracks a valid bit per stage register and keeps a saturating stall-cycle counter.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   fetch_valid     IF presents a valid instruction
//   id_rs1/2(_used) source registers of the IF/ID instruction
//   ex_rd, ex_rd_we, ex_is_load, ex_mc_start   ID/EX instruction attributes
//   mc_done         multi-cycle unit result pulse
//   branch_taken    ID/EX redirect
//   mem_stall       data memory wait, freezes whole pipe
//   pc_en, pipe_en, pipe_flush   PC/stage controls; index [0]=IF/ID .. [3]=MEM/WB
//   pipe_valid      valid bit of each stage register
//   mc_busy         waiting on the multi-cycle unit
//   stall_cycles    saturating count of cycles with pc_en low
module riscv_v_pipe_ctrl #(
    parameter int REG_ADDR_WIDTH  = 5,
    parameter int STALL_CNT_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       fetch_valid,
    input  logic [REG_ADDR_WIDTH-1:0]  id_rs1,
    input  logic [REG_ADDR_WIDTH-1:0]  id_rs2,
    input  logic                       id_rs1_used,
    input  logic                       id_rs2_used,
    input  logic [REG_ADDR_WIDTH-1:0]  ex_rd,
    input  logic                       ex_rd_we,
    input  logic                       ex_is_load,
    input  logic                       ex_mc_start,
    input  logic                       mc_done,
    input  logic                       branch_taken,
    input  logic                       mem_stall,
    output logic                       pc_en,
    output logic [3:0]                 pipe_en,
    output logic [3:0]                 pipe_flush,
    output logic [3:0]                 pipe_valid,
    output logic                       mc_busy,
    output logic [STALL_CNT_WIDTH-1:0] stall_cycles
);
    typedef enum logic {RUN, MC_BUSY} state_t;
    localparam logic [STALL_CNT_WIDTH-1:0] CNT_ONE = 1;
    state_t                     state_q, state_d;
    logic                       mc_done_q, mc_done_d;
    logic [3:0]                 valid_q, valid_d;
    logic [STALL_CNT_WIDTH-1:0] stall_q, stall_d;
    logic                       load_use, v_ex, done_any;
    assign v_ex     = valid_q[1];
    assign done_any = mc_done | mc_done_q;
    assign load_use = valid_q[0] & v_ex & ex_is_load & ex_rd_we & (ex_rd != '0) &
                      ((id_rs1_used & (id_rs1 == ex_rd)) | (id_rs2_used & (id_rs2 == ex_rd)));
    always_comb begin
        state_d    = state_q;
        mc_done_d  = mc_done_q;
        pc_en      = 1'b1;
        pipe_en    = 4'b1111;
        pipe_flush = 4'b0000;
        if (rst) begin
            pc_en   = 1'b0;
            pipe_en = 4'b0000;
        end else if (mem_stall) begin
            // a completion arriving while frozen is remembered for when the pipe thaws
            pc_en     = 1'b0;
            pipe_en   = 4'b0000;
            mc_done_d = mc_done_q | ((state_q == MC_BUSY) & mc_done);
        end else if (state_q == MC_BUSY) begin
            if (!done_any) begin
                pc_en      = 1'b0;
                pipe_en    = 4'b1000;
                pipe_flush = 4'b0100;
            end else begin
                state_d   = RUN;
                mc_done_d = 1'b0;
            end
        end else if (v_ex && branch_taken) begin
            pipe_flush = 4'b0011;
        end else if (v_ex && ex_mc_start) begin
            pc_en      = 1'b0;
            pipe_en    = 4'b1000;
            pipe_flush = 4'b0100;
            state_d    = MC_BUSY;
        end else if (load_use) begin
            pc_en      = 1'b0;
            pipe_en    = 4'b1100;
            pipe_flush = 4'b0010;
        end
    end
    // flush dominates enable, mirroring the stage register priority
    always_comb begin
        valid_d[0] = pipe_flush[0] ? 1'b0 : pipe_en[0] ? fetch_valid : valid_q[0];
        for (int i = 1; i < 4; i++)
            valid_d[i] = pipe_flush[i] ? 1'b0 : pipe_en[i] ? valid_q[i-1] : valid_q[i];
    end
    assign stall_d = (!pc_en && stall_q != '1) ? stall_q + CNT_ONE : stall_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RUN;
            mc_done_q <= 1'b0;
            valid_q   <= 4'b0000;
            stall_q   <= '0;
        end else begin
            state_q   <= state_d;
            mc_done_q <= mc_done_d;
            valid_q   <= valid_d;
            stall_q   <= stall_d;
        end
    end
    assign pipe_valid   = valid_q;
    assign mc_busy      = (state_q == MC_BUSY);
    assign stall_cycles = stall_q;
endmodule

// File: tb/tb_riscv_v_pipe_ctrl.sv
// tb_riscv_v_pipe_ctrl: directed bench with a rule-level reference model for riscv_v_pipe_ctrl.
module tb_riscv_v_pipe_ctrl;
    logic clk = 1'b0;
    logic rst, fetch_valid, id_rs1_used, id_rs2_used, ex_rd_we, ex_is_load, ex_mc_start;
    logic mc_done, branch_taken, mem_stall;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic pc_en, mc_busy, s_pc, s_busy;
    logic [3:0] pipe_en, pipe_flush, pipe_valid, s_en, s_fl, s_valid;
    logic [31:0] stall_cycles;
    logic [2:0] stall3;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    riscv_v_pipe_ctrl u_dut (
        .clk(clk), .rst(rst), .fetch_valid(fetch_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_rd(ex_rd), .ex_rd_we(ex_rd_we),
        .ex_is_load(ex_is_load), .ex_mc_start(ex_mc_start), .mc_done(mc_done),
        .branch_taken(branch_taken), .mem_stall(mem_stall), .pc_en(pc_en), .pipe_en(pipe_en),
        .pipe_flush(pipe_flush), .pipe_valid(pipe_valid), .mc_busy(mc_busy),
        .stall_cycles(stall_cycles));
    riscv_v_pipe_ctrl #(.STALL_CNT_WIDTH(3)) u_sat (
        .clk(clk), .rst(rst), .fetch_valid(fetch_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_rd(ex_rd), .ex_rd_we(ex_rd_we),
        .ex_is_load(ex_is_load), .ex_mc_start(ex_mc_start), .mc_done(mc_done),
        .branch_taken(branch_taken), .mem_stall(mem_stall), .pc_en(s_pc), .pipe_en(s_en),
        .pipe_flush(s_fl), .pipe_valid(s_valid), .mc_busy(s_busy), .stall_cycles(stall3));
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    // Reference model: picks the winning priority rule, then looks up its controls.
    // Each entry is {pc_en, pipe_en[3:0], pipe_flush[3:0]}.
    logic [8:0] act_tbl [0:6] = '{9'b0_0000_0000,   // mem_stall freeze
                                  9'b0_1000_0100,   // waiting on multi-cycle unit
                                  9'b1_1111_0000,   // multi-cycle done
                                  9'b1_1111_0011,   // taken branch squash
                                  9'b0_1000_0100,   // multi-cycle start
                                  9'b0_1100_0010,   // load-use bubble
                                  9'b1_1111_0000};  // normal flow
    bit m_busy, m_pend;
    logic [3:0] m_v;
    int m_cnt;
    always @(negedge clk) begin
        int r;
        bit lu;
        logic [8:0] a;
        logic [3:0] e_en, e_fl, nv;
        if (rst) begin
            m_busy = 0; m_pend = 0; m_v = 4'b0000; m_cnt = 0;
            chk("rst_pc_en", {s_pc, pc_en}, 0);
            chk("rst_pipe_en", {s_en, pipe_en}, 0);
            chk("rst_flush", {s_fl, pipe_flush}, 0);
            chk("rst_valid", {s_valid, pipe_valid}, 0);
            chk("rst_busy", {s_busy, mc_busy}, 0);
            chk("rst_cnt", {stall3, stall_cycles}, 0);
        end else begin
            lu = m_v[0] && m_v[1] && ex_is_load && ex_rd_we && ex_rd != 0 &&
                 ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
            if (mem_stall) r = 0;
            else if (m_busy) r = (mc_done || m_pend) ? 2 : 1;
            else if (m_v[1] && branch_taken) r = 3;
            else if (m_v[1] && ex_mc_start) r = 4;
            else if (lu) r = 5;
            else r = 6;
            a = act_tbl[r];
            e_en = a[7:4];
            e_fl = a[3:0];
            chk("pc_en", pc_en, a[8]);
            chk("pipe_en", pipe_en, e_en);
            chk("pipe_flush", pipe_flush, e_fl);
            chk("pipe_valid", pipe_valid, m_v);
            chk("mc_busy", mc_busy, m_busy);
            chk("stall_cycles", stall_cycles, m_cnt);
            chk("sat_pc_en", s_pc, a[8]);
            chk("sat_pipe_en", s_en, e_en);
            chk("sat_stall", stall3, m_cnt > 7 ? 7 : m_cnt);
            for (int i = 0; i < 4; i++)
                nv[i] = e_fl[i] ? 1'b0 : e_en[i] ? (i == 0 ? fetch_valid : m_v[i-1]) : m_v[i];
            m_v = nv;
            if (r == 0 && m_busy && mc_done) m_pend = 1;
            if (r == 2) begin m_busy = 0; m_pend = 0; end
            if (r == 4) m_busy = 1;
            if (!a[8]) m_cnt++;
        end
    end
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic look;
        @(negedge clk);
    endtask
    task automatic clear;
        fetch_valid = 1; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
        ex_rd = 0; ex_rd_we = 0; ex_is_load = 0; ex_mc_start = 0; mc_done = 0;
        branch_taken = 0; mem_stall = 0;
    endtask
    logic [31:0] s0;
    logic [7:0] fv_pat;
    initial begin
        rst = 1;
        clear();
        look;
        chk("lit_rst_pc", pc_en, 0);
        chk("lit_rst_en", pipe_en, 0);
        tick; rst = 0;
        look;
        chk("lit_run_en", pipe_en, 4'b1111);
        chk("lit_run_pc", pc_en, 1);
        chk("lit_valid0", pipe_valid, 4'b0000);
        tick; tick; look;
        chk("lit_fill2", pipe_valid, 4'b0011);
        tick; tick; look;
        chk("lit_fill4", pipe_valid, 4'b1111);
        // load x5 in ID/EX, consumer reads x5
        tick; ex_is_load = 1; ex_rd_we = 1; ex_rd = 5; id_rs1 = 5; id_rs1_used = 1;
        look;
        chk("lit_lu_pc", pc_en, 0);
        chk("lit_lu_en", pipe_en, 4'b1100);
        chk("lit_lu_fl", pipe_flush, 4'b0010);
        tick; look;
        chk("lit_lu_next_en", pipe_en, 4'b1111);
        chk("lit_lu_valid", pipe_valid, 4'b1101);
        // load to x0 never stalls
        tick; ex_rd = 0; id_rs1 = 0;
        look;
        chk("lit_x0_pc", pc_en, 1);
        // branch and load-use together: branch wins, no stall counted
        tick; ex_rd = 7; id_rs1_used = 0; id_rs2 = 7; id_rs2_used = 1; branch_taken = 1;
        look;
        s0 = stall_cycles;
        chk("lit_br_fl", pipe_flush, 4'b0011);
        chk("lit_br_pc", pc_en, 1);
        tick; branch_taken = 0;
        look;
        chk("lit_br_nostall", stall_cycles, s0);
        chk("lit_br_valid", pipe_valid, 4'b1100);
        chk("lit_lu_vex0_pc", pc_en, 1);
        // multi-cycle op, done after 4 waiting cycles
        tick; clear();
        tick; ex_mc_start = 1;
        look;
        s0 = stall_cycles;
        chk("lit_mc_en", pipe_en, 4'b1000);
        chk("lit_mc_fl", pipe_flush, 4'b0100);
        chk("lit_mc_busy0", mc_busy, 0);
        repeat (4) begin
            tick; look;
            chk("lit_mc_wait_en", pipe_en, 4'b1000);
            chk("lit_mc_wait_busy", mc_busy, 1);
        end
        tick; mc_done = 1; ex_mc_start = 0;
        look;
        chk("lit_mc_done_en", pipe_en, 4'b1111);
        chk("lit_mc_stall5", stall_cycles, s0 + 5);
        tick; mc_done = 0;
        look;
        chk("lit_mc_run", mc_busy, 0);
        // done arrives during mem_stall, consumed when the stall drops
        tick; ex_mc_start = 1;
        tick; ex_mc_start = 0;
        tick; mem_stall = 1; mc_done = 1;
        look;
        chk("lit_ms_en", pipe_en, 4'b0000);
        chk("lit_ms_busy", mc_busy, 1);
        tick; mc_done = 0;
        tick; mem_stall = 0;
        look;
        chk("lit_ms_exit_en", pipe_en, 4'b1111);
        chk("lit_ms_exit_pc", pc_en, 1);
        tick; look;
        chk("lit_ms_exit_busy", mc_busy, 0);
        // done outside MC_BUSY is ignored, even during mem_stall
        tick; mem_stall = 1; mc_done = 1;
        tick; mem_stall = 0; mc_done = 0; ex_mc_start = 1;
        tick; ex_mc_start = 0;
        look;
        chk("lit_ign_done_en", pipe_en, 4'b1000);
        // reset during MC_BUSY discards a pending done
        tick; mem_stall = 1; mc_done = 1;
        tick; mc_done = 0; rst = 1;
        look;
        chk("lit_rst_busy", mc_busy, 0);
        tick; rst = 0; mem_stall = 0;
        tick; tick; ex_mc_start = 1;
        tick; ex_mc_start = 0;
        look;
        chk("lit_rst_pend_en", pipe_en, 4'b1000);
        tick; mc_done = 1;
        tick; mc_done = 0;
        // fetch bubbles propagate through the valid bits
        fv_pat = 8'b1011_0010;
        for (int i = 0; i < 8; i++) begin
            fetch_valid = fv_pat[i];
            tick;
        end
        fetch_valid = 1;
        // long memory stall saturates the narrow counter
        mem_stall = 1;
        repeat (10) tick;
        mem_stall = 0;
        look;
        chk("lit_sat7", stall3, 3'd7);
        repeat (3) tick;
        look;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
